// File: rtl/seq_detect_scheduler_if.sv
// Bus bundle between the per-channel word sources, the scheduler and the shared
// 1011 detector.
interface seq_detect_scheduler_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 8
);
  localparam int unsigned ID_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]       req;
  logic [NUM_CH*WIDTH-1:0] req_data;
  logic [NUM_CH-1:0]       gnt;
  logic                    busy;
  logic                    det_reset;
  logic                    det_bit;
  logic                    seq_seen;
  logic                    done;
  logic [ID_W-1:0]         done_id;
  logic [3:0]              match_count;

  modport master (
    output req, req_data, seq_seen,
    input  gnt, busy, det_reset, det_bit, done, done_id, match_count
  );

  modport slave (
    input  req, req_data, seq_seen,
    output gnt, busy, det_reset, det_bit, done, done_id, match_count
  );
endinterface

// File: rtl/seq_detect_scheduler.sv
// Round-robin scheduler time-sharing one bit-serial 1011 detector among NUM_CH
// requesters; returns the per-word match count tagged with the channel id.
module seq_detect_scheduler #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 8
) (
  input logic                   clk,
  input logic                   reset,
  seq_detect_scheduler_if.slave bus
);
  localparam int unsigned ID_W  = $clog2(NUM_CH);
  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   done_id_q, done_id_d;
  logic [WIDTH-1:0]  sh_q, sh_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  match_count_q, match_count_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [NUM_CH-1:0] gnt_c;
  logic              found;
  logic [ID_W-1:0]   cand;

  // Next-state, arbitration and result computation.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    id_d          = id_q;
    done_id_d     = done_id_q;
    sh_d          = sh_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    match_count_d = match_count_q;
    gnt_c         = '0;
    found         = 1'b0;
    cand          = '0;

    case (state_q)
      IDLE: begin
        if (!reset) begin
          for (int i = 0; i < NUM_CH; i++) begin
            cand = rr_ptr_q + ID_W'(i);
            if (!found && bus.req[cand]) begin
              found       = 1'b1;
              gnt_c[cand] = 1'b1;
              id_d        = cand;
              sh_d        = bus.req_data[int'(cand)*WIDTH +: WIDTH];
              rr_ptr_d    = cand + ID_W'(1);
              state_d     = CLEAR;
            end
          end
        end
      end
      CLEAR: begin
        idx_d   = '0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        sh_d  = sh_q << 1;
        idx_d = idx_q + IDX_W'(1);
        // First sample after the detector clear carries no information.
        if ((idx_q != '0) && bus.seq_seen) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (idx_q == IDX_W'(WIDTH - 1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        done_id_d     = id_q;
        match_count_d = cnt_q + CNT_W'(bus.seq_seen);
        state_d       = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      id_q          <= '0;
      done_id_q     <= '0;
      sh_q          <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      match_count_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      id_q          <= id_d;
      done_id_q     <= done_id_d;
      sh_q          <= sh_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      match_count_q <= match_count_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // Grant must land in the IDLE cycle that captures req_data, so it is decoded.
  assign bus.gnt         = gnt_c;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.done_id     = done_id_q;
  assign bus.match_count = match_count_q;
  assign bus.det_bit     = (state_q == SHIFT) & sh_q[WIDTH-1];
  assign bus.det_reset   = reset | (state_q == CLEAR);
endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Scoreboard bench for seq_detect_scheduler with a behavioural 1011 detector
// and a window-count reference model.
module tb_seq_detect_scheduler;
  localparam int NCH = 4;
  localparam int W   = 8;

  logic clk = 1'b0;
  logic reset;
  logic stub;
  logic hold_all;
  logic [3:0] win;

  seq_detect_scheduler_if #(.NUM_CH(NCH), .WIDTH(W)) bus ();

  seq_detect_scheduler #(.NUM_CH(NCH), .WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Shared detector: last four consumed bits, match flag registered.
  always @(posedge clk) begin
    if (bus.det_reset) win <= 4'b0000;
    else               win <= {win[2:0], bus.det_bit};
  end
  assign bus.seq_seen = stub | (win == 4'b1011);

  typedef struct {
    int id;
    int cnt;
    int due;
  } exp_t;

  exp_t           sb[$];
  exp_t           e;
  int             n_vec = 0;
  int             n_bad = 0;
  int             cyc = 0;
  int             next_ok = 0;
  int             ref_ptr = 0;
  int             last_id = 0;
  int             last_cnt = 0;
  int             g_cyc = -1000;
  int             c;
  logic [W-1:0]   g_word;
  logic [W-1:0]   word_c;
  logic [NCH-1:0] exp_g;
  logic [NCH-1:0] gnt_seen = '0;
  int             exp_bit;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic int pick(input logic [NCH-1:0] r, input int p);
    int res = -1;
    for (int k = 0; k < NCH; k++) begin
      if (res < 0 && r[(p + k) % NCH]) res = (p + k) % NCH;
    end
    return res;
  endfunction

  // Matches = number of 4-bit windows equal to 1011 in the MSB-first stream.
  function automatic int exp_count(input logic [W-1:0] w);
    int n = 0;
    if (stub) return W;
    for (int p = W - 1; p >= 3; p--) begin
      if (w[p -: 4] == 4'b1011) n++;
    end
    return n;
  endfunction

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      chk("rst_det_reset", int'(bus.det_reset), 1);
      chk("rst_gnt", int'(bus.gnt), 0);
      sb.delete();
      ref_ptr  = 0;
      last_id  = 0;
      last_cnt = 0;
      next_ok  = cyc + 1;
      g_cyc    = -1000;
      gnt_seen = '0;
    end else begin
      exp_g = '0;
      c = -1;
      if (cyc >= next_ok && bus.req != '0) begin
        c = pick(bus.req, ref_ptr);
        exp_g[c] = 1'b1;
      end
      chk("gnt", int'(bus.gnt), int'(exp_g));
      chk("busy", int'(bus.busy), int'(cyc < next_ok));
      if (c >= 0) begin
        word_c = bus.req_data[c*W +: W];
        e.id  = c;
        e.cnt = exp_count(word_c);
        e.due = cyc + W + 3;
        sb.push_back(e);
        g_cyc   = cyc;
        g_word  = word_c;
        ref_ptr = (c + 1) % NCH;
        next_ok = cyc + W + 4;
      end
      gnt_seen = gnt_seen | bus.gnt;

      chk("det_reset", int'(bus.det_reset), int'(cyc == g_cyc + 1));
      exp_bit = 0;
      if (cyc >= g_cyc + 2 && cyc <= g_cyc + W + 1) exp_bit = int'(g_word[W - 1 - (cyc - g_cyc - 2)]);
      chk("det_bit", int'(bus.det_bit), exp_bit);

      if (sb.size() != 0 && sb[0].due < cyc) begin
        chk("done_timeout", 0, 1);
        void'(sb.pop_front());
      end
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("done_spurious", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.due);
          chk("done_id", int'(bus.done_id), e.id);
          chk("match_count", int'(bus.match_count), e.cnt);
          last_id  = e.id;
          last_cnt = e.cnt;
        end
      end else begin
        chk("done_id_hold", int'(bus.done_id), last_id);
        chk("match_count_hold", int'(bus.match_count), last_cnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < NCH; k++) begin
      if (gnt_seen[k] && !hold_all) bus.req[k] = 1'b0;
    end
    gnt_seen = '0;
  endtask

  task automatic raise(input int ch, input logic [W-1:0] w);
    bus.req_data[ch*W +: W] = w;
    bus.req[ch] = 1'b1;
  endtask

  task automatic wait_quiet(input int budget);
    int n = 0;
    while (!(bus.req == '0 && sb.size() == 0 && !bus.busy) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) chk("quiet_timeout", 0, 1);
  endtask

  initial begin
    reset    = 1'b1;
    stub     = 1'b0;
    hold_all = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    repeat (3) tick();
    reset = 1'b0;

    raise(0, 8'b1011_0000);
    wait_quiet(50);
    raise(2, 8'b1011_0110);
    wait_quiet(50);
    raise(1, 8'h00);
    tick();
    raise(3, 8'hFF);
    wait_quiet(60);

    // All channels held high from reset: strict rotation.
    reset    = 1'b1;
    hold_all = 1'b1;
    bus.req_data = {NCH{8'hB0}};
    bus.req      = '1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (5 * (W + 4)) tick();
    bus.req  = '0;
    hold_all = 1'b0;
    wait_quiet(60);

    // Reset in the middle of SHIFT aborts the job.
    raise(2, 8'hB0);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    raise(1, 8'hB0);
    wait_quiet(60);

    // Detector stub stuck high, including the ignored first sample.
    stub = 1'b1;
    raise(3, W'($urandom));
    wait_quiet(60);
    stub = 1'b0;
    tick();

    for (int it = 0; it < 600; it++) begin
      tick();
      for (int k = 0; k < NCH; k++) begin
        if (!bus.req[k] && $urandom_range(0, 9) == 0) raise(k, W'($urandom));
        else if (bus.req[k] && $urandom_range(0, 40) == 0) bus.req[k] = 1'b0;
      end
    end
    bus.req = '0;
    wait_quiet(200);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end
endmodule

// File: doc/seq_detect_scheduler.md
# seq_detect_scheduler

Round-robin scheduler that shares one bit-serial 1011 sequence detector among NUM_CH requesters. It grants one requester at a time, captures that requester's WIDTH-bit word, and clears the detector. It then shifts the word into the detector MSB-first, counts the detector's seq_seen pulses, and returns the match count tagged with the channel id. It sits between the per-channel word sources and the single detector instance; the detector's clk is the same clk.

## Interface
- NUM_CH, 4, number of requesters; power of two, 2..8
- WIDTH, 8, bits per word; 4..15
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- req  in  NUM_CH  per-channel request; held high until matching gnt bit seen
- req_data  in  NUM_CH*WIDTH  flat words; channel c at [c*WIDTH +: WIDTH]
- gnt  out  NUM_CH  one-hot, one-cycle grant; req_data of granted channel captured that cycle
- busy  out  1  high in every state except IDLE
- det_reset  out  1  drives detector reset
- det_bit  out  1  drives detector inp_bit
- seq_seen  in  1  detector output (registered state decode, valid one cycle after bit consumed)
- done  out  1  one-cycle pulse, result valid
- done_id  out  log2(NUM_CH)  channel of completed word; held until next done
- match_count  out  4  number of seq_seen cycles for that word; held until next done

## Operation
- States: IDLE, CLEAR, SHIFT, DRAIN, DONE.
- IDLE:
  - if any req, grant first requesting channel at or after rr_ptr (wrapping modulo NUM_CH); pulse gnt, latch word and id, go CLEAR.
  - rr_ptr <= granted id + 1 (mod NUM_CH).
  - no req: stay, no gnt.
- CLEAR: det_reset=1 for exactly one cycle; bit index <= 0; counter <= 0; go SHIFT.
- SHIFT: det_bit = word[WIDTH-1-idx]; idx increments each cycle; after idx=WIDTH-1 go DRAIN.
- Counting: counter increments in every cycle where seq_seen=1 during SHIFT idx>=1 and during DRAIN (WIDTH samples, one per shifted bit); seq_seen at SHIFT idx=0 ignored (detector just cleared).
- DRAIN: det_bit=0, final seq_seen sample; go DONE.
- DONE: done=1, done_id and match_count register the latched id and final count (including DRAIN sample); go IDLE.
- det_bit=0 in all states except SHIFT; det_reset = reset OR (state==CLEAR).
- Counter cannot overflow: WIDTH<=15 gives at most 4 matches; no saturation logic.
- req on non-granted channels ignored until next IDLE; requests are never queued or dropped, only deferred.
- Detector state-transition quirks are transparent; the count reflects seq_seen cycles only.

## Timing
- Reset values: gnt=0, busy=0, done=0, done_id=0, match_count=0, det_bit=0, det_reset=1 (during reset), rr_ptr=0, state IDLE.
- Reset mid-operation: abort at the next edge, no done pulse, result outputs cleared to 0, detector cleared via det_reset.
- Grant at cycle T (IDLE): CLEAR T+1; SHIFT T+2..T+WIDTH+1; DRAIN T+WIDTH+2; done T+WIDTH+3; next possible grant T+WIDTH+4 (12 cycles per word at WIDTH=8).
- Simultaneous requests: exactly one gnt bit per grant; with all req held high, grant order from reset is 0,1,2,3,0,...
- gnt is never asserted while busy=1.
- A req deasserted before grant is simply not served.

## Test plan
- Ch0 req, word 8'b1011_0000, team 1011 detector attached -> gnt=4'b0001 at T, done at T+11, done_id=0, match_count=1.
- Ch2 word 8'b1011_0110 -> match_count=2 (overlapping 1011011), done_id=2.
- Ch1 word 8'h00, then ch3 word 8'hFF -> both match_count=0; done_id 1 then 3; second gnt 12 cycles after first.
- All four req held high from reset, words 8'hB0 -> grants 0,1,2,3,0 at 12-cycle spacing; each done match_count=1, done_id increments.
- reset pulsed during SHIFT -> no done, outputs 0, det_reset high; a following ch1 request with 8'hB0 gives match_count=1.
- seq_seen forced high by a stub for all WIDTH sample cycles and at SHIFT idx=0 -> match_count=8 (idx=0 sample ignored); det_bit equals the captured word MSB-first during SHIFT.
